// File: rtl/bus_addr_decoder_pkg.sv
// Shared bus definitions: decoder FSM states and bus-wide sizing constants.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEVID,
    CONNECT,
    ERROR
  } dec_state_t;

  localparam int DEV_ID_W   = 2;
  localparam int ADDR_BITS  = 15;
  localparam int NSLAVE_MAX = 4;

endpackage

// File: rtl/bus_addr_decoder_if.sv
// Decoder-facing bundle: master/arbiter requests, slave selects and slave returns.
interface bus_addr_decoder_if #(
  parameter int NSLAVE = 3
);
  logic              B_BUS_BSY;
  logic              B_ADDR_VALID;
  logic              B_BUS_OUT;
  logic              B_SPL_RESUME;
  logic [NSLAVE-1:0] AD_SEL;
  logic [NSLAVE-1:0] S_ACK;
  logic [NSLAVE-1:0] S_READY;
  logic [NSLAVE-1:0] S_SBSY;
  logic [NSLAVE-1:0] S_BUS_IN;
  logic              B_ACK;
  logic              B_READY;
  logic              B_SBSY;
  logic              B_BUS_IN;
  logic              DEC_ERR;
  logic              SPL_PEND;

  modport master (
    output B_BUS_BSY, B_ADDR_VALID, B_BUS_OUT, B_SPL_RESUME,
    output S_ACK, S_READY, S_SBSY, S_BUS_IN,
    input  AD_SEL, B_ACK, B_READY, B_SBSY, B_BUS_IN, DEC_ERR, SPL_PEND
  );

  modport slave (
    input  B_BUS_BSY, B_ADDR_VALID, B_BUS_OUT, B_SPL_RESUME,
    input  S_ACK, S_READY, S_SBSY, S_BUS_IN,
    output AD_SEL, B_ACK, B_READY, B_SBSY, B_BUS_IN, DEC_ERR, SPL_PEND
  );
endinterface

// File: rtl/bus_addr_decoder_resp_mux.sv
// Combinational return path: picks one slave's ACK/READY/SBSY/data, all zero when disabled.
module bus_resp_mux #(
  parameter int NSLAVE = 3,
  parameter int IDW    = 2
) (
  input  logic              en_i,
  input  logic [IDW-1:0]    sel_i,
  input  logic [NSLAVE-1:0] ack_i,
  input  logic [NSLAVE-1:0] ready_i,
  input  logic [NSLAVE-1:0] sbsy_i,
  input  logic [NSLAVE-1:0] data_i,
  output logic              ack_o,
  output logic              ready_o,
  output logic              sbsy_o,
  output logic              data_o
);

  always_comb begin
    ack_o   = 1'b0;
    ready_o = 1'b0;
    sbsy_o  = 1'b0;
    data_o  = 1'b0;
    for (int unsigned i = 0; i < NSLAVE; i++) begin
      if (en_i && (sel_i == IDW'(i))) begin
        ack_o   = ack_i[i];
        ready_o = ready_i[i];
        sbsy_o  = sbsy_i[i];
        data_o  = data_i[i];
      end
    end
  end

endmodule

// File: rtl/bus_addr_decoder.sv
// Serial device-ID decoder driving one-hot AD_SEL, with one outstanding split transaction.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int NSLAVE = 3,
  parameter int IDW    = DEV_ID_W
) (
  input logic              CLK,
  input logic              RSTN,
  bus_addr_decoder_if.slave bus
);

  localparam logic [IDW:0] NS_LIM = (IDW+1)'(NSLAVE);

  if (NSLAVE < 1 || NSLAVE > NSLAVE_MAX || IDW != DEV_ID_W) begin : g_bad_cfg
    $error("bus_addr_decoder: unsupported NSLAVE/IDW combination");
  end

  dec_state_t        state_q;
  logic              id0_q;
  logic [IDW-1:0]    act_id_q;
  logic [IDW-1:0]    spl_id_q;
  logic              act_valid_q;
  logic              spl_pend_q;
  logic              dec_err_q;
  logic [NSLAVE-1:0] ad_sel_q;

  logic [IDW-1:0]    id_d;
  logic              id_bad_d;
  logic              keep_sel_d;
  logic              sbsy_act;

  assign id_d     = {bus.B_BUS_OUT, id0_q};
  assign id_bad_d = ({1'b0, id_d} >= NS_LIM) || (spl_pend_q && (id_d == spl_id_q));
  // A split raised on the very cycle the bus drops must still keep its slave selected.
  assign keep_sel_d = sbsy_act || (spl_pend_q && (spl_id_q == act_id_q));

  bus_resp_mux #(
    .NSLAVE (NSLAVE),
    .IDW    (IDW)
  ) u_resp_mux (
    .en_i    (act_valid_q),
    .sel_i   (act_id_q),
    .ack_i   (bus.S_ACK),
    .ready_i (bus.S_READY),
    .sbsy_i  (bus.S_SBSY),
    .data_i  (bus.S_BUS_IN),
    .ack_o   (bus.B_ACK),
    .ready_o (bus.B_READY),
    .sbsy_o  (sbsy_act),
    .data_o  (bus.B_BUS_IN)
  );

  assign bus.B_SBSY   = sbsy_act;
  assign bus.AD_SEL   = ad_sel_q;
  assign bus.DEC_ERR  = dec_err_q;
  assign bus.SPL_PEND = spl_pend_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      id0_q       <= 1'b0;
      act_id_q    <= '0;
      spl_id_q    <= '0;
      act_valid_q <= 1'b0;
      spl_pend_q  <= 1'b0;
      dec_err_q   <= 1'b0;
      ad_sel_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.B_SPL_RESUME && spl_pend_q) begin
            act_id_q    <= spl_id_q;
            act_valid_q <= 1'b1;
            spl_pend_q  <= 1'b0;
            state_q     <= CONNECT;
          end else if (bus.B_BUS_BSY && bus.B_ADDR_VALID) begin
            id0_q   <= bus.B_BUS_OUT;
            state_q <= DEVID;
          end
        end
        DEVID: begin
          if (!bus.B_BUS_BSY) begin
            state_q <= IDLE;
          end else if (id_bad_d) begin
            dec_err_q <= 1'b1;
            state_q   <= ERROR;
          end else begin
            for (int unsigned i = 0; i < NSLAVE; i++) begin
              if (id_d == IDW'(i)) ad_sel_q[i] <= 1'b1;
            end
            act_id_q    <= id_d;
            act_valid_q <= 1'b1;
            state_q     <= CONNECT;
          end
        end
        CONNECT: begin
          if (sbsy_act) begin
            spl_pend_q <= 1'b1;
            spl_id_q   <= act_id_q;
          end
          if (!bus.B_BUS_BSY) begin
            if (!keep_sel_d) begin
              for (int unsigned i = 0; i < NSLAVE; i++) begin
                if (act_id_q == IDW'(i)) ad_sel_q[i] <= 1'b0;
              end
            end
            act_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        ERROR: begin
          if (!bus.B_BUS_BSY) begin
            dec_err_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_addr_decoder.sv
// Directed bench for bus_addr_decoder with a transaction-level reference model checked every cycle.
module tb_bus_addr_decoder;
  import bus_pkg::*;

  localparam int NS = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   run   = 1'b0;

  bus_addr_decoder_if #(.NSLAVE(NS)) bif ();

  bus_addr_decoder #(.NSLAVE(NS)) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which slaves are selected, who is talking, and what split is owed.
  bit sel[NS];
  int active   = -1;
  bit err      = 1'b0;
  bit pend     = 1'b0;
  int owner    = 0;
  int nbits    = 0;
  int idacc    = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      foreach (sel[k]) sel[k] = 1'b0;
      active = -1; err = 1'b0; pend = 1'b0; owner = 0; nbits = 0; idacc = 0;
    end else if (err) begin
      if (!bif.B_BUS_BSY) err = 1'b0;
    end else if (active >= 0) begin
      if (bif.S_SBSY[active]) begin pend = 1'b1; owner = active; end
      if (!bif.B_BUS_BSY) begin
        if (!(pend && owner == active)) sel[active] = 1'b0;
        active = -1;
      end
    end else if (nbits == 1) begin
      nbits = 0;
      if (bif.B_BUS_BSY) begin
        int id;
        id = idacc + 2 * int'(bif.B_BUS_OUT);
        if (id >= NS || (pend && id == owner)) err = 1'b1;
        else begin sel[id] = 1'b1; active = id; end
      end
    end else if (bif.B_SPL_RESUME && pend) begin
      active = owner; pend = 1'b0;
    end else if (bif.B_BUS_BSY && bif.B_ADDR_VALID) begin
      idacc = int'(bif.B_BUS_OUT); nbits = 1;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      logic [NS-1:0] es;
      foreach (sel[k]) es[k] = sel[k];
      chk("cyc_AD_SEL",   32'(bif.AD_SEL),   32'(es));
      chk("cyc_DEC_ERR",  32'(bif.DEC_ERR),  32'(err));
      chk("cyc_SPL_PEND", 32'(bif.SPL_PEND), 32'(pend));
      chk("cyc_B_ACK",    32'(bif.B_ACK),    (active >= 0) ? 32'(bif.S_ACK[active])    : 32'd0);
      chk("cyc_B_READY",  32'(bif.B_READY),  (active >= 0) ? 32'(bif.S_READY[active])  : 32'd0);
      chk("cyc_B_SBSY",   32'(bif.B_SBSY),   (active >= 0) ? 32'(bif.S_SBSY[active])   : 32'd0);
      chk("cyc_B_BUS_IN", 32'(bif.B_BUS_IN), (active >= 0) ? 32'(bif.S_BUS_IN[active]) : 32'd0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bif.B_BUS_BSY = 1'b0; bif.B_ADDR_VALID = 1'b0; bif.B_BUS_OUT = 1'b0; bif.B_SPL_RESUME = 1'b0;
  endtask

  task automatic send_id(input logic [1:0] id);
    bif.B_BUS_BSY = 1'b1; bif.B_ADDR_VALID = 1'b1; bif.B_BUS_OUT = id[0];
    cyc();
    bif.B_BUS_OUT = id[1];
    cyc();
  endtask

  task automatic split_on(input logic [1:0] id);
    send_id(id);
    bif.S_SBSY = '0; bif.S_SBSY[id] = 1'b1;
    cyc();
    bif.S_SBSY = '0;
    idle_bus();
    cyc();
  endtask

  initial begin
    logic [7:0] pat;
    idle_bus();
    bif.S_ACK = '1; bif.S_READY = '1; bif.S_SBSY = '0; bif.S_BUS_IN = '1;
    #1 rstn = 1'b0;
    #2;
    chk("rst_AD_SEL", 32'(bif.AD_SEL), 32'd0);
    chk("rst_DEC_ERR", 32'(bif.DEC_ERR), 32'd0);
    chk("rst_SPL_PEND", 32'(bif.SPL_PEND), 32'd0);
    chk("rst_B_ACK", 32'(bif.B_ACK), 32'd0);
    run = 1'b1;
    cyc(); cyc();
    bif.S_ACK = '0; bif.S_READY = '0; bif.S_BUS_IN = '0;
    rstn = 1'b1;
    cyc();

    // Slave 1 select, address phase, release
    send_id(2'd1);
    chk("sel1_AD_SEL", 32'(bif.AD_SEL), 32'h2);
    bif.S_ACK = 3'b010; #1;
    chk("sel1_B_ACK", 32'(bif.B_ACK), 32'd1);
    bif.S_ACK = 3'b101; #1;
    chk("sel1_B_ACK_other", 32'(bif.B_ACK), 32'd0);
    for (int i = 0; i < ADDR_BITS; i++) begin
      bif.B_BUS_OUT = 1'(i % 3); cyc();
    end
    bif.S_ACK = '0;
    idle_bus(); cyc();
    chk("sel1_release", 32'(bif.AD_SEL), 32'd0);

    // Invalid ID 3
    send_id(2'd3);
    chk("err_DEC_ERR", 32'(bif.DEC_ERR), 32'd1);
    chk("err_AD_SEL", 32'(bif.AD_SEL), 32'd0);
    bif.S_ACK = '1; bif.S_BUS_IN = '1; #1;
    chk("err_B_ACK", 32'(bif.B_ACK), 32'd0);
    chk("err_B_BUS_IN", 32'(bif.B_BUS_IN), 32'd0);
    cyc(); cyc();
    chk("err_held", 32'(bif.DEC_ERR), 32'd1);
    bif.S_ACK = '0; bif.S_BUS_IN = '0;
    idle_bus(); cyc();
    chk("err_clear", 32'(bif.DEC_ERR), 32'd0);

    // DEVID abort and resume-without-split are both ignored
    bif.B_BUS_BSY = 1'b1; bif.B_ADDR_VALID = 1'b1; bif.B_BUS_OUT = 1'b1; cyc();
    idle_bus(); cyc();
    chk("abort_AD_SEL", 32'(bif.AD_SEL), 32'd0);
    bif.B_SPL_RESUME = 1'b1; bif.B_BUS_BSY = 1'b1; cyc();
    idle_bus(); cyc();
    chk("spurious_resume", 32'(bif.AD_SEL), 32'd0);

    // Split on slave 2
    send_id(2'd2);
    chk("spl_sel", 32'(bif.AD_SEL), 32'h4);
    bif.S_SBSY = 3'b100; cyc();
    chk("spl_PEND", 32'(bif.SPL_PEND), 32'd1);
    bif.S_SBSY = '0; idle_bus(); cyc();
    chk("spl_hold", 32'(bif.AD_SEL), 32'h4);
    send_id(2'd0);
    chk("spl_two_sel", 32'(bif.AD_SEL), 32'h5);
    bif.S_READY = 3'b100; #1;
    chk("spl_ready_owner", 32'(bif.B_READY), 32'd0);
    bif.S_READY = 3'b001; #1;
    chk("spl_ready_act", 32'(bif.B_READY), 32'd1);
    bif.S_READY = '0; idle_bus(); cyc();
    chk("spl_drop0", 32'(bif.AD_SEL), 32'h4);
    send_id(2'd2);
    chk("spl_busy_err", 32'(bif.DEC_ERR), 32'd1);
    idle_bus(); cyc();

    // Resume slave 2 and stream 8'hAD back LSB first
    bif.B_SPL_RESUME = 1'b1; bif.B_BUS_BSY = 1'b1; cyc();
    bif.B_SPL_RESUME = 1'b0;
    chk("res_PEND", 32'(bif.SPL_PEND), 32'd0);
    chk("res_sel", 32'(bif.AD_SEL), 32'h4);
    pat = 8'hAD;
    for (int i = 0; i < 8; i++) begin
      bif.S_BUS_IN = {pat[i], ~pat[i], ~pat[i]}; #1;
      chk("res_data", 32'(bif.B_BUS_IN), 32'(pat[i]));
      cyc();
    end
    bif.S_BUS_IN = '0; idle_bus(); cyc();
    chk("res_done", 32'(bif.AD_SEL), 32'd0);

    // Resume beats a simultaneous new request
    split_on(2'd1);
    bif.B_SPL_RESUME = 1'b1; bif.B_BUS_BSY = 1'b1; bif.B_ADDR_VALID = 1'b1; bif.B_BUS_OUT = 1'b0;
    cyc();
    bif.B_SPL_RESUME = 1'b0; cyc();
    chk("prio_sel", 32'(bif.AD_SEL), 32'h2);
    chk("prio_PEND", 32'(bif.SPL_PEND), 32'd0);
    bif.S_ACK = 3'b010; #1;
    chk("prio_B_ACK", 32'(bif.B_ACK), 32'd1);
    bif.S_ACK = '0; idle_bus(); cyc();
    chk("prio_done", 32'(bif.AD_SEL), 32'd0);

    // Async reset during DEVID with a split outstanding
    split_on(2'd2);
    bif.B_BUS_BSY = 1'b1; bif.B_ADDR_VALID = 1'b1; bif.B_BUS_OUT = 1'b0; cyc();
    #1 rstn = 1'b0;
    #1;
    chk("arst_AD_SEL", 32'(bif.AD_SEL), 32'd0);
    chk("arst_SPL_PEND", 32'(bif.SPL_PEND), 32'd0);
    idle_bus(); cyc();
    rstn = 1'b1; cyc();

    // Async reset while in ERROR
    send_id(2'd3);
    #1 rstn = 1'b0;
    #1;
    chk("arst_DEC_ERR", 32'(bif.DEC_ERR), 32'd0);
    idle_bus(); cyc();
    rstn = 1'b1; cyc();

    // Split record lost: slave 2 is selectable again
    send_id(2'd2);
    chk("post_rst_sel", 32'(bif.AD_SEL), 32'h4);
    chk("post_rst_err", 32'(bif.DEC_ERR), 32'd0);
    idle_bus(); cyc(); cyc();

    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_addr_decoder.md
Name: bus_addr_decoder

Overview:
Sits between the bus arbiter/master mux and the slave ports, directly upstream of each slave's AD_SEL input. It receives a 2-bit serial device ID ahead of each transaction and asserts the matching one-hot AD_SEL. It returns the selected slave's ACK/READY/SBSY/BUS_IN to the master side. It also tracks one outstanding split transaction, keeping the split slave selected until its read resumes and completes.

Parameters:
NSLAVE, 3, number of slave ports (1..4); device IDs >= NSLAVE are a decode error.
IDW, 2, device-ID width; fixed at 2 for NSLAVE<=4.

Ports:
CLK  in  1  bus clock.
RSTN  in  1  reset, asynchronous, active-low.
B_BUS_BSY  in  1  arbiter: transaction in progress (granted master owns bus).
B_ADDR_VALID  in  1  master: ID/address phase active.
B_BUS_OUT  in  1  master->slave serial data (ID bits, then address/data).
B_SPL_RESUME  in  1  arbiter: resume the split transaction.
AD_SEL  out  NSLAVE  per-slave select, registered.
S_ACK  in  NSLAVE  slave ACK returns.
S_READY  in  NSLAVE  slave READY returns.
S_SBSY  in  NSLAVE  slave split-busy returns.
S_BUS_IN  in  NSLAVE  slave->master serial data.
B_ACK  out  1  muxed ACK of the active slave.
B_READY  out  1  muxed READY.
B_SBSY  out  1  muxed SBSY.
B_BUS_IN  out  1  muxed read data.
DEC_ERR  out  1  invalid/busy device ID, registered.
SPL_PEND  out  1  a split transaction is outstanding, registered.

Behaviour:
- Reset (async, RSTN=0): state=IDLE; AD_SEL=0; DEC_ERR=0; SPL_PEND=0; act_id=0; spl_id=0.
- Reset state of B_* return outputs: 0, because no slave is active.
- B_* return outputs: combinational mux of S_*[act_id], gated by act_valid; 0 when not active. Zero-cycle latency.
- ID is serial, LSB first, 1 bit per cycle while B_ADDR_VALID=1.
- States: IDLE, DEVID, CONNECT, ERROR.
- IDLE:
  - B_SPL_RESUME & SPL_PEND -> act_id=spl_id, SPL_PEND<=0, goto CONNECT. Resume has priority over a simultaneous B_ADDR_VALID; the new request is ignored.
  - Else B_BUS_BSY & B_ADDR_VALID -> id[0]<=B_BUS_OUT, goto DEVID.
- DEVID: id[1]<=B_BUS_OUT.
  - If id >= NSLAVE, or (SPL_PEND & id==spl_id) -> goto ERROR.
  - Else AD_SEL[id]<=1, act_id<=id, goto CONNECT.
  - AD_SEL is high on the cycle after the second ID bit, i.e. before the first of the slave's 15 address bits.
  - B_BUS_BSY=0 in DEVID -> abort to IDLE, no select.
- CONNECT: AD_SEL[act_id] held.
  - S_SBSY[act_id]=1 -> SPL_PEND<=1, spl_id<=act_id. AD_SEL[spl_id] stays asserted, because the slave needs AD_SEL to run its READ after resume.
  - B_BUS_BSY falls -> clear AD_SEL[act_id] unless act_id==spl_id & SPL_PEND; act_valid<=0; goto IDLE.
- Two AD_SEL bits may be high at once: split owner plus the new active slave. The return mux always follows act_id only.
- ERROR: DEC_ERR=1, no AD_SEL change, B_* returns=0. Held until B_BUS_BSY=0, then DEC_ERR<=0, goto IDLE.
- Completed resumed read: when B_BUS_BSY falls in CONNECT with act_id==spl_id, and SPL_PEND is already 0, AD_SEL[spl_id] is cleared.
- B_SPL_RESUME with SPL_PEND=0 is ignored.
- Reset mid-transaction: everything cleared asynchronously. The split record is lost.

Decomposition:
- Shared package bus_pkg:
  - dec_state_t enum {IDLE, DEVID, CONNECT, ERROR};
  - DEV_ID_W=2;
  - ADDR_BITS=15 (shared with slaves and master);
  - NSLAVE_MAX=4.
- One natural sub-module, bus_resp_mux: the combinational NSLAVE->1 mux of ACK/READY/SBSY/BUS_IN with enable.
- FSM, ID shifter and split register stay in bus_addr_decoder.

Test Plan:
- Select slave 1: B_BUS_BSY=1, B_ADDR_VALID=1, B_BUS_OUT bits 1,0 -> AD_SEL=3'b010 one cycle after the 2nd bit. S_ACK[1]=1 -> B_ACK=1 same cycle. B_BUS_BSY=0 -> AD_SEL=0 next cycle.
- Invalid ID 3 (bits 1,1) with NSLAVE=3 -> DEC_ERR=1 from next cycle until B_BUS_BSY=0; AD_SEL stays 0; B_ACK/B_BUS_IN=0.
- Split: select slave 2, S_SBSY[2]=1, drop B_BUS_BSY -> SPL_PEND=1, AD_SEL=3'b100 held.
  - New transaction to slave 0 -> AD_SEL=3'b101; B_READY follows S_READY[0] only.
  - New transaction to slave 2 -> DEC_ERR=1.
- Resume: with SPL_PEND=1, assert B_SPL_RESUME -> act_id=2, SPL_PEND=0. S_BUS_IN[2] pattern 8'hAD appears on B_BUS_IN bit-for-bit. B_BUS_BSY falls -> AD_SEL=0.
- Simultaneous B_SPL_RESUME and B_ADDR_VALID in IDLE -> resume wins; ID bits ignored; act_id=spl_id.
- RSTN pulse low mid-DEVID and mid-split -> AD_SEL=0, DEC_ERR=0, SPL_PEND=0 immediately, without waiting for a clock edge.
